act_lut_loader: RTL and testbench

Writer side of the activation-function LUT write port. Accepts a load command (function slot mask, base index, entry count) and a narrow data stream of coefficient words, assembles full {a_coef, b_coef} LUT entries, and issues one single-cycle LUT write per entry. Sits between the host/config bus and the activation unit's write_enable/write_addr/write_data inputs.

---
 rtl/act_lut_loader.sv | 194 +++++++++++++++++++
 tb/tb_act_lut_loader.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/act_lut_loader.sv
// Activation LUT write-port loader: assembles narrow coefficient beats into LUT entries and strobes one write per entry.
// Optional running entry checksum is enabled by defining ACT_LOADER_CHECKSUM_EN.
module act_lut_loader #(
  parameter int unsigned ACT_MASK_SIZE = 4,
  parameter int unsigned ACT_LUT_DEPTH = 6,
  parameter int unsigned ACT_LUT_SIZE  = 32,
  parameter int unsigned IN_W          = 16
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   cmd_valid,
  output logic                                   cmd_ready,
  input  logic [ACT_MASK_SIZE-1:0]               cmd_mask,
  input  logic [ACT_LUT_DEPTH-1:0]               cmd_base,
  input  logic [ACT_LUT_DEPTH:0]                 cmd_count,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [IN_W-1:0]                        in_data,
  input  logic                                   abort,
  output logic                                   lut_write_enable,
  output logic [ACT_MASK_SIZE+ACT_LUT_DEPTH-1:0] lut_write_addr,
  output logic [ACT_LUT_SIZE-1:0]                lut_write_data,
  output logic                                   busy,
  output logic                                   done,
  output logic                                   err,
  output logic [15:0]                            checksum
);

  localparam int unsigned BEATS  = (ACT_LUT_SIZE + IN_W - 1) / IN_W;
  localparam int unsigned PAD_W  = BEATS * IN_W;
  localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned CNT_W  = ACT_LUT_DEPTH + 1;
  localparam int unsigned ADDR_W = ACT_MASK_SIZE + ACT_LUT_DEPTH;
  localparam logic [CNT_W-1:0]  MAX_COUNT = CNT_W'(2 ** ACT_LUT_DEPTH);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

  state_t                   state_q, state_d;
  logic [ACT_MASK_SIZE-1:0] mask_q, mask_d;
  logic [ACT_LUT_DEPTH-1:0] index_q, index_d;
  logic [CNT_W-1:0]         remain_q, remain_d;
  logic [BEAT_W-1:0]        beat_q, beat_d;
  logic [PAD_W-1:0]         buf_q, buf_d;
  logic [ADDR_W-1:0]        addr_q, addr_d;
  logic [ACT_LUT_SIZE-1:0]  data_q, data_d;
  logic                     cmd_ready_q, cmd_ready_d;
  logic                     in_ready_q, in_ready_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     err_q, err_d;
  logic                     cmd_fire, in_fire, cmd_ok;

  assign cmd_fire = cmd_valid && cmd_ready_q;
  assign in_fire  = in_valid && in_ready_q;
  assign cmd_ok   = (cmd_count != '0) && (cmd_count <= MAX_COUNT);

  // Strobe is gated live so abort or reset in the WRITE cycle suppresses it
  assign lut_write_enable = (state_q == WRITE) && !abort && !rst;
  assign lut_write_addr   = addr_q;
  assign lut_write_data   = data_q;
  assign cmd_ready        = cmd_ready_q;
  assign in_ready         = in_ready_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign err              = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mask_q      <= '0;
      index_q     <= '0;
      remain_q    <= '0;
      beat_q      <= '0;
      buf_q       <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      cmd_ready_q <= 1'b1;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      index_q     <= index_d;
      remain_q    <= remain_d;
      beat_q      <= beat_d;
      buf_q       <= buf_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      cmd_ready_q <= cmd_ready_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    index_d  = index_q;
    remain_d = remain_q;
    beat_d   = beat_q;
    buf_d    = buf_q;
    addr_d   = addr_q;
    data_d   = data_q;
    err_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (cmd_fire) begin
          if (!cmd_ok) begin
            err_d = 1'b1;
          end else begin
            mask_d   = cmd_mask;
            index_d  = cmd_base;
            remain_d = cmd_count;
            beat_d   = '0;
            state_d  = LOAD;
          end
        end
      end
      LOAD: begin
        if (abort) begin
          state_d = IDLE;
          beat_d  = '0;
        end else if (in_fire) begin
          // Shift in so that beat 0 ends up in the MSBs after BEATS beats
          buf_d = (buf_q << IN_W) | PAD_W'(in_data);
          if (beat_q == LAST_BEAT) begin
            beat_d  = '0;
            addr_d  = {mask_q, index_q};
            data_d  = buf_d[PAD_W-1 -: ACT_LUT_SIZE];
            state_d = WRITE;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      WRITE: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          index_d  = index_q + ACT_LUT_DEPTH'(1);
          remain_d = remain_q - CNT_W'(1);
          state_d  = (remain_q == CNT_W'(1)) ? DONE : LOAD;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    cmd_ready_d = (state_d == IDLE);
    in_ready_d  = (state_d == LOAD);
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == DONE);
  end

`ifdef ACT_LOADER_CHECKSUM_EN
  localparam int unsigned CS_CHUNKS = (ACT_LUT_SIZE + 15) / 16;
  localparam int unsigned CS_PAD_W  = CS_CHUNKS * 16;

  logic [CS_PAD_W-1:0] cs_pad;
  logic [15:0]         chunk_sum;
  logic [15:0]         cs_q;

  assign cs_pad = CS_PAD_W'(data_q);

  // Modular sum of the 16-bit chunks of the entry being written
  always_comb begin
    chunk_sum = '0;
    for (int i = 0; i < int'(CS_CHUNKS); i++) begin
      chunk_sum = chunk_sum + cs_pad[i*16 +: 16];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cs_q <= '0;
    end else if (state_q == IDLE && cmd_fire && cmd_ok) begin
      cs_q <= '0;
    end else if (lut_write_enable) begin
      cs_q <= cs_q + chunk_sum;
    end
  end

  assign checksum = cs_q;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_act_lut_loader.sv
// Directed self-checking bench for act_lut_loader: reset, loads, slot wrap, gaps, illegal counts, abort, reset mid-load.
module tb_act_lut_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_mask;
  logic [5:0]  cmd_base;
  logic [6:0]  cmd_count;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        abort;
  logic        lut_write_enable;
  logic [9:0]  lut_write_addr;
  logic [31:0] lut_write_data;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] checksum;

  always #5 clk = ~clk;

  act_lut_loader dut (
    .clk              (clk),
    .rst              (rst),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_mask         (cmd_mask),
    .cmd_base         (cmd_base),
    .cmd_count        (cmd_count),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_data          (in_data),
    .abort            (abort),
    .lut_write_enable (lut_write_enable),
    .lut_write_addr   (lut_write_addr),
    .lut_write_data   (lut_write_data),
    .busy             (busy),
    .done             (done),
    .err              (err),
    .checksum         (checksum)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int done_cyc = 0;
  int beats_seen = 0;
  bit busy_seen = 1'b0;
  logic [15:0] cs_at_done = '0;
  logic [9:0]  wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          wr_cyc_q[$];
  int          fb_cyc_q[$];

  // Observe the bus mid-cycle; a final beat seen now should produce a strobe one cycle later
  always @(negedge clk) begin
    cyc++;
    if (lut_write_enable) begin
      wr_addr_q.push_back(lut_write_addr);
      wr_data_q.push_back(lut_write_data);
      wr_cyc_q.push_back(cyc);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      cs_at_done = checksum;
    end
    if (err) err_cnt++;
    if (busy) busy_seen = 1'b1;
    if (cmd_valid && cmd_ready) beats_seen = 0;
    if (in_valid && in_ready) begin
      beats_seen++;
      if (beats_seen % 2 == 0) fb_cyc_q.push_back(cyc + 1);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cyc_q.delete();
    fb_cyc_q.delete();
    busy_seen = 1'b0;
  endtask

  task automatic send_cmd(input logic [3:0] m, input logic [5:0] b, input logic [6:0] c);
    bit ok = 1'b0;
    cmd_mask  = m;
    cmd_base  = b;
    cmd_count = c;
    cmd_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (cmd_ready) ok = 1'b1;
      tick();
    end
    cmd_valid = 1'b0;
    if (!ok) chk("cmd_accept_timeout", 64'(ok), 64'(1));
  endtask

  task automatic send_beat(input logic [15:0] d, input bit gap);
    bit ok = 1'b0;
    if (gap) tick();
    in_data  = d;
    in_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (in_ready) ok = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    if (!ok) chk("beat_accept_timeout", 64'(ok), 64'(1));
  endtask

  task automatic wait_done(input int prev);
    for (int i = 0; i < 50 && done_cnt == prev; i++) tick();
    chk("done_seen", 64'(done_cnt), 64'(prev + 1));
  endtask

  initial begin
    int d0;
    int e0;
    logic [15:0] exp_cs;
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_mask = '0;
    cmd_base = '0;
    cmd_count = '0;
    in_valid = 1'b0;
    in_data = '0;
    abort = 1'b0;

    // Reset
    tick();
    tick();
    chk("rst_we", 64'(lut_write_enable), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    rst = 1'b0;
    tick();
    chk("rst_cmd_ready", 64'(cmd_ready), 64'(1));
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    chk("rst_addr", 64'(lut_write_addr), 64'(0));
    chk("rst_data", 64'(lut_write_data), 64'(0));
    chk("rst_checksum", 64'(checksum), 64'(0));
    chk("rst_no_writes", 64'(wr_addr_q.size()), 64'(0));

    // Basic two-entry load
    clear_log();
    d0 = done_cnt;
    send_cmd(4'd3, 6'd0, 7'd2);
    send_beat(16'h1234, 1'b0);
    send_beat(16'h5678, 1'b0);
    send_beat(16'h9ABC, 1'b0);
    send_beat(16'hDEF0, 1'b0);
    wait_done(d0);
    chk("basic_nwr", 64'(wr_addr_q.size()), 64'(2));
    chk("basic_addr0", 64'(wr_addr_q[0]), 64'h0C0);
    chk("basic_data0", 64'(wr_data_q[0]), 64'h12345678);
    chk("basic_addr1", 64'(wr_addr_q[1]), 64'h0C1);
    chk("basic_data1", 64'(wr_data_q[1]), 64'h9ABCDEF0);
    chk("basic_lat0", 64'(wr_cyc_q[0]), 64'(fb_cyc_q[0]));
    chk("basic_lat1", 64'(wr_cyc_q[1]), 64'(fb_cyc_q[1]));
    chk("basic_done_cyc", 64'(done_cyc), 64'(wr_cyc_q[1] + 1));
    chk("basic_idle_busy", 64'(busy), 64'(0));
    chk("basic_idle_ready", 64'(cmd_ready), 64'(1));
    chk("basic_hold_addr", 64'(lut_write_addr), 64'h0C1);
    chk("basic_hold_data", 64'(lut_write_data), 64'h9ABCDEF0);
`ifdef ACT_LOADER_CHECKSUM_EN
    exp_cs = 16'h1234 + 16'h5678 + 16'h9ABC + 16'hDEF0;
`else
    exp_cs = 16'h0000;
`endif
    chk("basic_checksum", 64'(cs_at_done), 64'(exp_cs));

    // Index wraps inside the slot
    clear_log();
    d0 = done_cnt;
    send_cmd(4'd1, 6'd63, 7'd2);
    send_beat(16'hA001, 1'b0);
    send_beat(16'hA002, 1'b0);
    send_beat(16'hB001, 1'b0);
    send_beat(16'hB002, 1'b0);
    wait_done(d0);
    chk("wrap_nwr", 64'(wr_addr_q.size()), 64'(2));
    chk("wrap_addr0", 64'(wr_addr_q[0]), 64'h07F);
    chk("wrap_addr1", 64'(wr_addr_q[1]), 64'h040);
    chk("wrap_data1", 64'(wr_data_q[1]), 64'hB001B002);

    // Gapped input stream
    clear_log();
    d0 = done_cnt;
    send_cmd(4'd2, 6'd5, 7'd2);
    send_beat(16'hCAFE, 1'b1);
    send_beat(16'hF00D, 1'b1);
    send_beat(16'h0BAD, 1'b1);
    send_beat(16'hBEEF, 1'b1);
    wait_done(d0);
    chk("gap_nwr", 64'(wr_addr_q.size()), 64'(2));
    chk("gap_addr0", 64'(wr_addr_q[0]), 64'h085);
    chk("gap_data0", 64'(wr_data_q[0]), 64'hCAFEF00D);
    chk("gap_addr1", 64'(wr_addr_q[1]), 64'h086);
    chk("gap_data1", 64'(wr_data_q[1]), 64'h0BADBEEF);
    chk("gap_lat0", 64'(wr_cyc_q[0]), 64'(fb_cyc_q[0]));
    chk("gap_lat1", 64'(wr_cyc_q[1]), 64'(fb_cyc_q[1]));

    // Illegal counts
    clear_log();
    e0 = err_cnt;
    send_cmd(4'd0, 6'd0, 7'd0);
    tick();
    send_cmd(4'd0, 6'd0, 7'd65);
    tick();
    tick();
    chk("illegal_err", 64'(err_cnt - e0), 64'(2));
    chk("illegal_nwr", 64'(wr_addr_q.size()), 64'(0));
    chk("illegal_busy", 64'(busy_seen), 64'(0));

    // Abort part way into the second entry
    clear_log();
    d0 = done_cnt;
    send_cmd(4'd0, 6'd10, 7'd4);
    send_beat(16'hAAAA, 1'b0);
    send_beat(16'hBBBB, 1'b0);
    send_beat(16'hCCCC, 1'b0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_cmd_ready", 64'(cmd_ready), 64'(1));
    chk("abort_busy", 64'(busy), 64'(0));
    for (int i = 0; i < 5; i++) tick();
    chk("abort_nwr", 64'(wr_addr_q.size()), 64'(1));
    chk("abort_addr0", 64'(wr_addr_q[0]), 64'h00A);
    chk("abort_data0", 64'(wr_data_q[0]), 64'hAAAABBBB);
    chk("abort_no_done", 64'(done_cnt), 64'(d0));

    // Reset landing on the write cycle
    clear_log();
    d0 = done_cnt;
    send_cmd(4'd5, 6'd0, 7'd1);
    send_beat(16'h1111, 1'b0);
    send_beat(16'h2222, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    tick();
    chk("rstmid_nwr", 64'(wr_addr_q.size()), 64'(0));
    chk("rstmid_no_done", 64'(done_cnt), 64'(d0));
    chk("rstmid_busy", 64'(busy), 64'(0));
    chk("rstmid_cmd_ready", 64'(cmd_ready), 64'(1));
    chk("rstmid_addr", 64'(lut_write_addr), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
